// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parameterised synchronous FIFO with standard or FWFT read, level flags and sticky errors
module param_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT = 0,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 rd_en,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH || (FWFT != 0 && FWFT != 1)) begin : g_bad_params
    $error("param_sync_fifo: invalid parameter combination");
  end
  assign full = count == CNT_WIDTH'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= CNT_WIDTH'(AF_LEVEL);
  assign almost_empty = count <= CNT_WIDTH'(AE_LEVEL);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  // storage is never reset; a write in a reset cycle is discarded
  always_ff @(posedge clk)
    if (wr_acc && !rst) mem[wr_ptr] <= wdata;
  // pointers with non-power-of-two wrap, occupancy and sticky error flags
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_acc ? (wr_ptr == PTR_W'(DEPTH - 1) ? '0 : wr_ptr + 1'b1) : wr_ptr;
      rd_ptr <= rd_acc ? (rd_ptr == PTR_W'(DEPTH - 1) ? '0 : rd_ptr + 1'b1) : rd_ptr;
      count <= (wr_acc && !rd_acc) ? count + 1'b1 : (rd_acc && !wr_acc) ? count - 1'b1 : count;
      overflow <= (overflow && !err_clr) || (wr_en && full);
      underflow <= (underflow && !err_clr) || (rd_en && empty);
    end
  if (FWFT == 1) begin : g_fwft
    assign rdata = empty ? '0 : mem[rd_ptr];
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;
    // registered read: loads only on an accepted pop, otherwise holds
    always_ff @(posedge clk)
      if (rst) rdata_q <= '0;
      else if (rd_acc) rdata_q <= mem[rd_ptr];
    assign rdata = rdata_q;
  end
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed table-driven checks of param_sync_fifo in default, DEPTH=5 and FWFT configurations
module tb_param_sync_fifo;
  logic clk = 0;
  always #5 clk = ~clk;
  int errs = 0, checks = 0;
  logic a_rst = 1, a_wr = 0, a_rd = 0, a_clr = 0;
  logic [7:0] a_wd = 0, a_rdata;
  logic a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0] a_cnt;
  logic b_rst = 1, b_wr = 0, b_rd = 0, b_clr = 0;
  logic [7:0] b_wd = 0, b_rdata;
  logic b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_cnt;
  logic f_rst = 1, f_wr = 0, f_rd = 0, f_clr = 0;
  logic [7:0] f_wd = 0, f_rdata;
  logic f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_cnt;
  param_sync_fifo u_a (.clk(clk), .rst(a_rst), .wr_en(a_wr), .wdata(a_wd), .rd_en(a_rd), .err_clr(a_clr),
    .rdata(a_rdata), .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .count(a_cnt), .overflow(a_ovf), .underflow(a_unf));
  param_sync_fifo #(.DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_b (.clk(clk), .rst(b_rst), .wr_en(b_wr), .wdata(b_wd),
    .rd_en(b_rd), .err_clr(b_clr), .rdata(b_rdata), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_unf));
  param_sync_fifo #(.FWFT(1)) u_f (.clk(clk), .rst(f_rst), .wr_en(f_wr), .wdata(f_wd), .rd_en(f_rd), .err_clr(f_clr),
    .rdata(f_rdata), .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_cnt), .overflow(f_ovf), .underflow(f_unf));
  typedef struct {
    logic rst, wr, rd, clr;
    logic [7:0] wd;
    int cnt;
    logic [7:0] rdata;
    logic ovf, unf;
  } vec_t;
  vec_t v[$];
  function automatic void add(logic rst, logic wr, logic rd, logic clr, logic [7:0] wd, int cnt,
                              logic [7:0] rdata, logic ovf, logic unf);
    vec_t t;
    t.rst = rst; t.wr = wr; t.rd = rd; t.clr = clr; t.wd = wd;
    t.cnt = cnt; t.rdata = rdata; t.ovf = ovf; t.unf = unf;
    v.push_back(t);
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic bstep(logic wr, logic rd, logic [7:0] wd);
    b_wr = wr; b_rd = rd; b_wd = wd;
    @(posedge clk); #1;
  endtask
  task automatic fstep(logic wr, logic rd, logic [7:0] wd);
    f_wr = wr; f_rd = rd; f_wd = wd;
    @(posedge clk); #1;
  endtask
  initial begin
    add(1, 1, 0, 0, 8'hEE, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 8'(i), i + 1, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 0, 1, 0, 8'h00, 15 - i, 8'(i), 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h0F, 0, 1);
    add(0, 1, 1, 0, 8'h55, 1, 8'h0F, 0, 1);
    add(0, 0, 0, 1, 8'h00, 1, 8'h0F, 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h55, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 8'(8'h10 + i), i + 1, 8'h55, 0, 0);
    add(0, 1, 1, 0, 8'hAA, 15, 8'h10, 1, 0);
    for (int i = 0; i < 15; i++) add(0, 0, 1, 0, 8'h00, 14 - i, 8'(8'h11 + i), 1, 0);
    add(0, 0, 0, 1, 8'h00, 0, 8'h1F, 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h1F, 0, 1);
    add(0, 0, 1, 1, 8'h00, 0, 8'h1F, 0, 1);
    add(0, 0, 0, 1, 8'h00, 0, 8'h1F, 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h1F, 0, 1);
    for (int i = 0; i < 7; i++) add(0, 1, 0, 0, 8'(8'h30 + i), i + 1, 8'h1F, 0, 1);
    add(1, 1, 0, 0, 8'hEE, 0, 8'h00, 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1);
    add(0, 1, 0, 0, 8'h77, 1, 8'h00, 0, 1);
    add(0, 0, 1, 0, 8'h00, 0, 8'h77, 0, 1);
    foreach (v[i]) begin
      a_rst = v[i].rst; a_wr = v[i].wr; a_rd = v[i].rd; a_clr = v[i].clr; a_wd = v[i].wd;
      @(posedge clk); #1;
      chk($sformatf("v%0d count", i), 32'(a_cnt), 32'(v[i].cnt));
      chk($sformatf("v%0d rdata", i), 32'(a_rdata), 32'(v[i].rdata));
      chk($sformatf("v%0d flags", i), 32'({a_full, a_empty, a_af, a_ae, a_ovf, a_unf}),
          32'({v[i].cnt == 16, v[i].cnt == 0, v[i].cnt >= 14, v[i].cnt <= 2, v[i].ovf, v[i].unf}));
    end
    a_rst = 0; a_wr = 0; a_rd = 0; a_clr = 0;
    chk("d5 reset empty", 32'({b_empty, b_ae, b_full, b_cnt}), 32'({1'b1, 1'b1, 1'b0, 3'd0}));
    b_rst = 0;
    for (int k = 0; k < 3; k++) begin
      bstep(1, 0, 8'(8'h40 + k));
      chk($sformatf("d5 pre%0d count", k), 32'(b_cnt), 32'(k + 1));
    end
    for (int j = 0; j < 12; j++) begin
      bstep(1, 1, 8'(8'h43 + j));
      chk($sformatf("d5 pair%0d rdata", j), 32'(b_rdata), 32'(8'h40 + j));
      chk($sformatf("d5 pair%0d count", j), 32'(b_cnt), 32'd3);
    end
    for (int j = 0; j < 3; j++) begin
      bstep(0, 1, 8'h00);
      chk($sformatf("d5 drain%0d rdata", j), 32'(b_rdata), 32'(8'h4C + j));
      chk($sformatf("d5 drain%0d count", j), 32'(b_cnt), 32'(2 - j));
    end
    for (int k = 0; k < 5; k++) begin
      bstep(1, 0, 8'(8'h50 + k));
      chk($sformatf("d5 fill%0d count", k), 32'(b_cnt), 32'(k + 1));
    end
    chk("d5 full", 32'({b_full, b_af}), 32'({1'b1, 1'b1}));
    bstep(1, 0, 8'h99);
    chk("d5 overflow count", 32'({b_cnt, b_ovf}), 32'({3'd5, 1'b1}));
    for (int k = 0; k < 5; k++) begin
      bstep(0, 1, 8'h00);
      chk($sformatf("d5 out%0d rdata", k), 32'(b_rdata), 32'(8'h50 + k));
    end
    chk("d5 end empty", 32'(b_empty), 32'd1);
    bstep(0, 0, 8'h00);
    chk("fwft reset", 32'({f_empty, f_rdata}), 32'({1'b1, 8'h00}));
    f_rst = 0;
    fstep(1, 0, 8'h3C);
    chk("fwft first word", 32'({f_empty, f_rdata}), 32'({1'b0, 8'h3C}));
    fstep(0, 0, 8'h00);
    chk("fwft hold", 32'({f_cnt, f_rdata}), 32'({5'd1, 8'h3C}));
    fstep(0, 1, 8'h00);
    chk("fwft pop to empty", 32'({f_empty, f_rdata}), 32'({1'b1, 8'h00}));
    fstep(1, 0, 8'hA1);
    fstep(1, 0, 8'hA2);
    chk("fwft two words", 32'({f_cnt, f_rdata}), 32'({5'd2, 8'hA1}));
    fstep(0, 1, 8'h00);
    chk("fwft second word", 32'({f_cnt, f_rdata}), 32'({5'd1, 8'hA2}));
    fstep(0, 1, 8'h00);
    chk("fwft drained", 32'({f_empty, f_rdata, f_unf}), 32'({1'b1, 8'h00, 1'b0}));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of storage entries (>=2; power of two NOT required).
REQ-003 Parameter AF_LEVEL, default 14, almost-full threshold in words.
REQ-004 Parameter AE_LEVEL, default 2, almost-empty threshold in words.
REQ-005 Parameter FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 Derived CNT_WIDTH = $clog2(DEPTH+1), not user-overridable.
REQ-007 One clock; reset is synchronous and active-high.
REQ-008 clk  input  1  sole clock; all state updates on rising edge.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 wr_en  input  1  write request.
REQ-011 wdata  input  WIDTH  write data, sampled with wr_en.
REQ-012 rd_en  input  1  read/pop request.
REQ-013 err_clr  input  1  clears sticky overflow/underflow.
REQ-014 rdata  output  WIDTH  read data.
REQ-015 full  output  1  count == DEPTH.
REQ-016 empty  output  1  count == 0.
REQ-017 almost_full  output  1  count >= AF_LEVEL.
REQ-018 almost_empty  output  1  count <= AE_LEVEL.
REQ-019 count  output  CNT_WIDTH  current occupancy, 0..DEPTH.
REQ-020 overflow  output  1  sticky: write attempted while full.
REQ-021 underflow  output  1  sticky: read attempted while empty.

Function
REQ-022 Elaboration SHALL fail unless 0 <= AE_LEVEL < AF_LEVEL <= DEPTH and FWFT is 0 or 1.
REQ-023 Write accepted iff wr_en && !full; accepted write stores wdata at wr_ptr, then wr_ptr advances; wr_ptr == DEPTH-1 wraps to 0.
REQ-024 Read accepted iff rd_en && !empty; accepted read advances rd_ptr with the same wrap rule.
REQ-025 count, registered: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write+read or on neither.
REQ-026 full/empty/almost_full/almost_empty SHALL be combinational decodes of registered count only (no comb path from wr_en/rd_en).
REQ-027 Full with wr_en && rd_en: read accepted, write rejected, overflow set; count becomes DEPTH-1.
REQ-028 Empty with wr_en && rd_en: write accepted, read rejected, underflow set; count becomes 1.
REQ-029 FWFT=0: accepted read loads rdata with mem[rd_ptr] at that edge (1-cycle latency); otherwise rdata holds.
REQ-030 FWFT=1: rdata = mem[rd_ptr] combinationally when !empty, 0 when empty; first write into empty FIFO visible on rdata the cycle after the write edge; rd_en acts as pop/acknowledge.
REQ-031 overflow/underflow SHALL stay 1 until rst or err_clr; new error event coinciding with err_clr leaves the flag set.
REQ-032 Rejected operations SHALL not alter pointers, count, memory or rdata.

Reset
REQ-033 rst (sampled at clk edge) SHALL clear wr_ptr, rd_ptr, count, rdata, overflow, underflow to 0; hence empty=1, almost_empty=1, full=0, almost_full=0.
REQ-034 wr_en/rd_en SHALL be ignored in any cycle rst is high; reset mid-operation discards all stored words.
REQ-035 Memory contents SHALL not be reset; no rdata value may expose them after reset until rewritten.

Verification
REQ-036 Defaults, FWFT=0: write 16 words 0x00..0x0F -> full=1, count=16, almost_full=1 from count=14; read 16 -> rdata 0x00..0x0F each one cycle after rd_en, then empty=1.
REQ-037 Full, wr_en+rd_en one cycle with wdata=0xAA -> overflow=1, count=15, 0xAA never read out; err_clr pulse -> overflow=0.
REQ-038 Empty, rd_en alone -> underflow=1, rdata unchanged; empty with wr_en+rd_en, wdata=0x55 -> count=1, underflow=1.
REQ-039 DEPTH=5, 12 interleaved write/read pairs crossing wrap -> data order preserved, count never exceeds 5.
REQ-040 FWFT=1: write 0x3C into empty -> next cycle empty=0, rdata=0x3C without rd_en; rd_en -> empty=1, rdata=0.
REQ-041 rst asserted with count=7 and wr_en=1 -> next cycle count=0, empty=1, flags cleared, write discarded.
